// File: rtl/counter_share_sched.sv
// counter_share_sched: round-robin owner of one shared external counter.
// The scheduler grants one requester at a time, clears the counter, enables it
// until it reaches that requester's latched run length, then pulses done.
// An overflow or a dropped request aborts the run with a one-cycle err pulse.
module counter_share_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 busy,
    output logic                 cnt_rst_n,
    output logic                 cnt_en,
    input  logic [CW-1:0]        cnt_val,
    input  logic                 cnt_ovf
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   own, own_n;
    logic [CW-1:0]   tgt, tgt_n;
    logic [NREQ-1:0] gnt_n;
    logic [NREQ-1:0] done_n;
    logic            err_n;
    logic            cnt_rst_n_n;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   ptr_after;
    logic            own_req;
    logic            match;
    int              scan_idx;

    // Round-robin search: first asserted request starting at ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(scan_idx);
            end
        end
    end

    // Pointer value that hands priority to the requester after the owner.
    always_comb begin
        if (int'(own) == NREQ - 1) begin
            ptr_after = '0;
        end else begin
            ptr_after = own + PW'(1);
        end
    end

    assign own_req = req[own];
    assign match   = (cnt_val == tgt);
    assign busy    = (state != IDLE);

    // Next-state logic, registered-output next values and the counter enable.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        own_n       = own;
        tgt_n       = tgt;
        gnt_n       = gnt;
        done_n      = '0;
        err_n       = 1'b0;
        cnt_rst_n_n = 1'b0;
        cnt_en      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    own_n   = pick_idx;
                    tgt_n   = len[int'(pick_idx)*CW +: CW];
                    gnt_n   = NREQ'(1) << pick_idx;
                    state_n = CLR;
                end
            end
            CLR: begin
                cnt_rst_n_n = 1'b1;
                state_n     = RUN;
            end
            RUN: begin
                cnt_en = !match && !cnt_ovf && own_req;
                if (cnt_ovf || !own_req) begin
                    err_n   = 1'b1;
                    gnt_n   = '0;
                    ptr_n   = ptr_after;
                    state_n = IDLE;
                end else if (match) begin
                    done_n  = gnt;
                    state_n = DONE;
                end else begin
                    cnt_rst_n_n = 1'b1;
                end
            end
            DONE: begin
                gnt_n   = '0;
                ptr_n   = ptr_after;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            ptr       <= '0;
            own       <= '0;
            tgt       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            cnt_rst_n <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            own       <= own_n;
            tgt       <= tgt_n;
            gnt       <= gnt_n;
            done      <= done_n;
            err       <= err_n;
            cnt_rst_n <= cnt_rst_n_n;
        end
    end

endmodule

// File: tb/tb_counter_share_sched.sv
// Directed testbench for counter_share_sched with a behavioural shared counter.
module tb_counter_share_sched;

    logic        CLK;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic        cnt_rst_n;
    logic        cnt_en;
    logic [7:0]  cnt_val;
    logic        cnt_ovf;

    int compared;
    int mismatched;

    counter_share_sched #(.NREQ(4), .CW(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .len       (len),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .cnt_rst_n (cnt_rst_n),
        .cnt_en    (cnt_en),
        .cnt_val   (cnt_val),
        .cnt_ovf   (cnt_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // The external counter the scheduler shares.
    always_ff @(posedge CLK) begin
        if (!cnt_rst_n) begin
            cnt_val <= 8'd0;
        end else if (cnt_en) begin
            cnt_val <= cnt_val + 8'd1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] l);
        req = r;
        len = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From an IDLE cycle with req applied: check grant, then done latency.
    task automatic runOne(input string tag, input logic [3:0] expGnt, input int tlen);
        int doneCyc;
        bit errSeen;
        tick();
        checkOutput({tag, " gnt"}, 32'(gnt), 32'(expGnt));
        doneCyc = -1;
        errSeen = 1'b0;
        for (int c = 2; c <= tlen + 10; c++) begin
            tick();
            if (err) errSeen = 1'b1;
            if (done != 4'b0000) begin
                doneCyc = c;
                break;
            end
        end
        checkOutput({tag, " done"}, 32'(done), 32'(expGnt));
        checkOutput({tag, " done cycle"}, 32'(doneCyc), 32'(3 + tlen));
        checkOutput({tag, " no err"}, 32'(errSeen), 32'(0));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        RST        = 1'b0;
        cnt_ovf    = 1'b0;
        applyStimulus(4'b0000, 32'h0);

        // Reset state
        tick();
        tick();
        checkOutput("rst gnt", 32'(gnt), 32'(0));
        checkOutput("rst done", 32'(done), 32'(0));
        checkOutput("rst err", 32'(err), 32'(0));
        checkOutput("rst busy", 32'(busy), 32'(0));
        checkOutput("rst cnt_rst_n", 32'(cnt_rst_n), 32'(0));
        checkOutput("rst cnt_en", 32'(cnt_en), 32'(0));
        RST = 1'b1;
        tick();

        // Single request, length 5, cycle by cycle
        applyStimulus(4'b0001, 32'h0000_0005);
        tick();
        checkOutput("t1 c1 gnt", 32'(gnt), 32'(4'b0001));
        checkOutput("t1 c1 busy", 32'(busy), 32'(1));
        checkOutput("t1 c1 cnt_en", 32'(cnt_en), 32'(0));
        checkOutput("t1 c1 cnt_rst_n", 32'(cnt_rst_n), 32'(0));
        tick();
        checkOutput("t1 c2 cnt_val", 32'(cnt_val), 32'(0));
        checkOutput("t1 c2 cnt_rst_n", 32'(cnt_rst_n), 32'(1));
        checkOutput("t1 c2 cnt_en", 32'(cnt_en), 32'(1));
        for (int c = 3; c <= 6; c++) begin
            tick();
            checkOutput("t1 cnt_en run", 32'(cnt_en), 32'(1));
        end
        tick();
        checkOutput("t1 c7 cnt_val", 32'(cnt_val), 32'(5));
        checkOutput("t1 c7 cnt_en", 32'(cnt_en), 32'(0));
        checkOutput("t1 c7 done", 32'(done), 32'(0));
        tick();
        checkOutput("t1 c8 done", 32'(done), 32'(4'b0001));
        checkOutput("t1 c8 gnt", 32'(gnt), 32'(4'b0001));
        applyStimulus(4'b0000, 32'h0000_0005);
        tick();
        checkOutput("t1 c9 gnt", 32'(gnt), 32'(0));
        checkOutput("t1 c9 busy", 32'(busy), 32'(0));
        checkOutput("t1 c9 done", 32'(done), 32'(0));

        // Reset again so the round-robin pointer starts at 0
        RST = 1'b0;
        tick();
        RST = 1'b1;

        // Two simultaneous requests, then all four held: order 0,2,3,0,1,2
        applyStimulus(4'b0101, 32'h0303_0303);
        runOne("t2 r0", 4'b0001, 3);
        applyStimulus(4'b0100, 32'h0303_0303);
        tick();
        checkOutput("t2 idle gnt", 32'(gnt), 32'(0));
        checkOutput("t2 idle busy", 32'(busy), 32'(0));
        runOne("t2 r2", 4'b0100, 3);
        applyStimulus(4'b1111, 32'h0303_0303);
        tick();
        runOne("t2 r3", 4'b1000, 3);
        tick();
        runOne("t2 r0 wrap", 4'b0001, 3);
        tick();
        runOne("t2 r1", 4'b0010, 3);
        tick();
        runOne("t2 r2b", 4'b0100, 3);
        applyStimulus(4'b0000, 32'h0303_0303);
        tick();

        // Zero length: done at cycle 3, counter never enabled
        applyStimulus(4'b0001, 32'h0000_0000);
        tick();
        checkOutput("t3 len0 gnt", 32'(gnt), 32'(4'b0001));
        checkOutput("t3 len0 c1 cnt_en", 32'(cnt_en), 32'(0));
        tick();
        checkOutput("t3 len0 c2 cnt_en", 32'(cnt_en), 32'(0));
        checkOutput("t3 len0 c2 done", 32'(done), 32'(0));
        tick();
        checkOutput("t3 len0 c3 done", 32'(done), 32'(4'b0001));
        checkOutput("t3 len0 c3 cnt_en", 32'(cnt_en), 32'(0));
        applyStimulus(4'b0000, 32'h0000_0000);
        tick();

        // Maximum length 255: done at cycle 258, no error
        applyStimulus(4'b0001, 32'h0000_00FF);
        runOne("t3 len255", 4'b0001, 255);
        applyStimulus(4'b0000, 32'h0000_00FF);
        tick();

        // Request dropped at cycle 4 of a length-10 run; pointer then at 1
        applyStimulus(4'b0001, 32'h0000_010A);
        tick();
        checkOutput("t4 gnt", 32'(gnt), 32'(4'b0001));
        tick();
        tick();
        tick();
        applyStimulus(4'b0000, 32'h0000_010A);
        #1;
        checkOutput("t4 drop cnt_en", 32'(cnt_en), 32'(0));
        tick();
        checkOutput("t4 err", 32'(err), 32'(1));
        checkOutput("t4 gnt off", 32'(gnt), 32'(0));
        checkOutput("t4 no done", 32'(done), 32'(0));
        checkOutput("t4 busy", 32'(busy), 32'(0));
        tick();
        checkOutput("t4 err pulse", 32'(err), 32'(0));
        applyStimulus(4'b0011, 32'h0000_010A);
        runOne("t4 ptr1", 4'b0010, 1);
        applyStimulus(4'b0000, 32'h0000_010A);
        tick();

        // Overflow during RUN: enable drops at once, err next cycle
        applyStimulus(4'b0001, 32'h0000_000A);
        tick();
        tick();
        checkOutput("t5 cnt_en", 32'(cnt_en), 32'(1));
        tick();
        cnt_ovf = 1'b1;
        #1;
        checkOutput("t5 ovf cnt_en", 32'(cnt_en), 32'(0));
        tick();
        checkOutput("t5 err", 32'(err), 32'(1));
        checkOutput("t5 busy", 32'(busy), 32'(0));
        checkOutput("t5 gnt", 32'(gnt), 32'(0));
        cnt_ovf = 1'b0;
        applyStimulus(4'b0000, 32'h0000_000A);
        tick();
        checkOutput("t5 err pulse", 32'(err), 32'(0));

        // Reset mid-run: everything cleared, pointer back to 0
        applyStimulus(4'b0001, 32'h0303_030A);
        tick();
        tick();
        tick();
        RST = 1'b0;
        tick();
        checkOutput("t6 gnt", 32'(gnt), 32'(0));
        checkOutput("t6 done", 32'(done), 32'(0));
        checkOutput("t6 err", 32'(err), 32'(0));
        checkOutput("t6 busy", 32'(busy), 32'(0));
        checkOutput("t6 cnt_rst_n", 32'(cnt_rst_n), 32'(0));
        checkOutput("t6 cnt_en", 32'(cnt_en), 32'(0));
        RST = 1'b1;
        applyStimulus(4'b1111, 32'h0303_030A);
        tick();
        checkOutput("t6 regrant ptr0", 32'(gnt), 32'(4'b0001));
        RST = 1'b0;
        applyStimulus(4'b0000, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
